sram_1rw_ctrl: RTL and testbench



---
 rtl/sram_1rw_ctrl.sv | 145 ++++++++++++++
 tb/tb_sram_1rw_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_ctrl.sv
// sram_1rw_ctrl: requester-side controller for a single-port, masked-write SRAM macro
// with one cycle of read latency.
// After reset it sweeps zeros into every entry. It then shares the single RW port
// between a write request channel and a read request channel. Read data is returned
// on a valid/ready response channel, and one response is buffered under backpressure.
//
// Ports
//   clock, reset                 sole clock; asynchronous active-high reset
//   i_w_valid / o_w_ready        write request handshake (i_w_addr, i_w_data, i_w_mask)
//   i_r_req_valid / o_r_req_ready read request handshake (i_r_req_addr)
//   o_r_resp_valid / i_r_resp_ready read response handshake (o_r_resp_data)
//   o_init_done                  high once the clear sweep has completed
//   o_sram_*                     SRAM port: enable, write mode, address, mask, write data
//   i_sram_rdata                 SRAM read data, valid the cycle after a read enable
module sram_1rw_ctrl #(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 308,
  parameter int unsigned MASK_SEGS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_w_valid,
  output logic                 o_w_ready,
  input  logic [ADDR_W-1:0]    i_w_addr,
  input  logic [DATA_W-1:0]    i_w_data,
  input  logic [MASK_SEGS-1:0] i_w_mask,
  input  logic                 i_r_req_valid,
  output logic                 o_r_req_ready,
  input  logic [ADDR_W-1:0]    i_r_req_addr,
  output logic                 o_r_resp_valid,
  input  logic                 i_r_resp_ready,
  output logic [DATA_W-1:0]    o_r_resp_data,
  output logic                 o_init_done,
  output logic                 o_sram_en,
  output logic                 o_sram_wmode,
  output logic [ADDR_W-1:0]    o_sram_addr,
  output logic [MASK_SEGS-1:0] o_sram_wmask,
  output logic [DATA_W-1:0]    o_sram_wdata,
  input  logic [DATA_W-1:0]    i_sram_rdata
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StReset, StInit, StRun} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_pending;
  logic                r_hold_valid;
  logic                w_hold_valid_nxt;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_last_grant;
  logic                w_last_grant_nxt;

  logic w_run;
  logic w_rd_ok;
  logic w_contested;
  logic w_wr_fire;
  logic w_rd_fire;

  assign w_run = (r_state == StRun);

  // A read may only be issued if its response has a guaranteed slot. Either nothing is
  // in flight, or the in-flight response is being consumed this cycle.
  assign w_rd_ok     = !r_hold_valid && (!r_pending || i_r_resp_ready);
  assign w_contested = w_run && i_w_valid && i_r_req_valid && w_rd_ok;

  assign o_w_ready     = w_run && (!i_r_req_valid || !w_rd_ok || !r_last_grant);
  assign o_r_req_ready = w_run && w_rd_ok && (!i_w_valid || r_last_grant);
  assign w_wr_fire     = i_w_valid && o_w_ready;
  assign w_rd_fire     = i_r_req_valid && o_r_req_ready;

  assign o_init_done    = w_run;
  assign o_r_resp_valid = r_pending || r_hold_valid;
  assign o_r_resp_data  = r_hold_valid ? r_hold_data : i_sram_rdata;

  // Only a contested grant flips priority; the granted side loses it next time.
  assign w_last_grant_nxt = w_contested ? w_wr_fire : r_last_grant;

  // A response that is not taken in its first cycle moves into the hold buffer.
  assign w_hold_valid_nxt = r_hold_valid ? !i_r_resp_ready : (r_pending && !i_r_resp_ready);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_sram_en    = 1'b0;
    o_sram_wmode = 1'b0;
    // Idle cycles follow the write channel so the macro inputs stay quiet.
    o_sram_addr  = i_w_addr;
    o_sram_wmask = i_w_mask;
    o_sram_wdata = i_w_data;
    unique case (r_state)
      StReset: w_state_nxt = StInit;
      StInit: begin
        o_sram_en    = 1'b1;
        o_sram_wmode = 1'b1;
        o_sram_addr  = r_cnt;
        o_sram_wmask = {MASK_SEGS{1'b1}};
        o_sram_wdata = '0;
        w_cnt_nxt    = r_cnt + ADDR_W'(1);
        if (r_cnt == LastAddr) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_wr_fire) begin
          // An all-zero mask still completes the handshake but leaves the macro idle.
          o_sram_en    = |i_w_mask;
          o_sram_wmode = 1'b1;
        end else if (w_rd_fire) begin
          o_sram_en   = 1'b1;
          o_sram_addr = i_r_req_addr;
        end
      end
      default: w_state_nxt = StReset;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StReset;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pending    <= w_rd_fire;
      r_hold_valid <= w_hold_valid_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Data-only register; its contents are qualified by r_hold_valid.
  always_ff @(posedge clock) begin
    if (r_pending && !i_r_resp_ready) begin
      r_hold_data <= i_sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
module tb_sram_1rw_ctrl;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int DW    = 308;
  localparam int MS    = 4;
  localparam int SEG   = DW / MS;

  logic          clock = 1'b0;
  logic          reset;
  logic          w_valid, w_ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [MS-1:0] w_mask;
  logic          r_req_valid, r_req_ready;
  logic [AW-1:0] r_req_addr;
  logic          r_resp_valid, r_resp_ready;
  logic [DW-1:0] r_resp_data;
  logic          init_done;
  logic          sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [MS-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  sram_1rw_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .MASK_SEGS(MS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_w_valid(w_valid),
    .o_w_ready(w_ready),
    .i_w_addr(w_addr),
    .i_w_data(w_data),
    .i_w_mask(w_mask),
    .i_r_req_valid(r_req_valid),
    .o_r_req_ready(r_req_ready),
    .i_r_req_addr(r_req_addr),
    .o_r_resp_valid(r_resp_valid),
    .i_r_resp_ready(r_resp_ready),
    .o_r_resp_data(r_resp_data),
    .o_init_done(init_done),
    .o_sram_en(sram_en),
    .o_sram_wmode(sram_wmode),
    .o_sram_addr(sram_addr),
    .o_sram_wmask(sram_wmask),
    .o_sram_wdata(sram_wdata),
    .i_sram_rdata(sram_rdata)
  );

  // Behavioural SRAM macro: masked write, one-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int s = 0; s < MS; s++) begin
          if (sram_wmask[s]) mem[sram_addr][s*SEG +: SEG] <= sram_wdata[s*SEG +: SEG];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  function automatic logic [DW-1:0] pat(int a);
    logic [DW-1:0] v;
    v = DW'(a + 1) | (DW'(a + 17) << 280) | (DW'(a + 3) << 150);
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Single uncontested write; leaves the write channel idle afterwards.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MS-1:0] m);
    w_valid = 1'b1;
    w_addr  = a;
    w_data  = d;
    w_mask  = m;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({init_done, w_ready, r_req_ready, r_resp_valid, sram_en} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {init_done, w_ready, r_req_ready, r_resp_valid, sram_en});
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_checks++;
      if ({sram_en, sram_wmode, sram_wmask, sram_addr, w_ready, r_req_ready, init_done,
           (sram_wdata == '0)} !== {1'b1, 1'b1, 4'hf, AW'(i), 1'b0, 1'b0, 1'b0, 1'b1}) begin
        n_errors++;
        $display("FAIL init_sweep[%0d]: en=%b wm=%b mask=%h addr=%0d wr=%b rr=%b done=%b wd0=%b",
                 i, sram_en, sram_wmode, sram_wmask, sram_addr, w_ready, r_req_ready,
                 init_done, (sram_wdata == '0));
      end
    end
    tick();
    n_checks++;
    if ({init_done, sram_en, w_ready, r_req_ready} !== 4'b1011) begin
      n_errors++;
      $display("FAIL init_done_513: got %b want 1011", {init_done, sram_en, w_ready, r_req_ready});
    end
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] exp;
    exp = '0;
    exp[76:0]    = '1;
    exp[230:154] = '1;
    w_valid = 1'b1;
    w_addr  = 9'd5;
    w_data  = '1;
    w_mask  = 4'b0101;
    #1;
    n_checks++;
    if ({w_ready, sram_en, sram_wmode, sram_wmask, sram_addr} !== {3'b111, 4'b0101, 9'd5}) begin
      n_errors++;
      $display("FAIL mw_write: got %b want %b",
               {w_ready, sram_en, sram_wmode, sram_wmask, sram_addr}, {3'b111, 4'b0101, 9'd5});
    end
    tick();
    w_valid      = 1'b0;
    r_req_valid  = 1'b1;
    r_req_addr   = 9'd5;
    r_resp_ready = 1'b1;
    #1;
    n_checks++;
    if ({r_req_ready, sram_en, sram_wmode, sram_addr} !== {3'b110, 9'd5}) begin
      n_errors++;
      $display("FAIL mw_read_req: got %b want %b",
               {r_req_ready, sram_en, sram_wmode, sram_addr}, {3'b110, 9'd5});
    end
    tick();
    r_req_valid = 1'b0;
    #1;
    n_checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== exp) begin
      n_errors++;
      $display("FAIL mw_resp: valid=%b data=%h want valid=1 data=%h", r_resp_valid, r_resp_data, exp);
    end
    tick();
    n_checks++;
    if (r_resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mw_resp_once: valid=%b want 0", r_resp_valid);
    end
  endtask

  task automatic test_stream();
    int issued;
    int recv;
    logic stall;
    for (int a = 0; a < 8; a++) do_write(AW'(a), pat(a), 4'hf);
    issued = 0;
    recv   = 0;
    for (int c = 0; c < 20; c++) begin
      stall        = (c >= 3 && c <= 5);
      r_resp_ready = !stall;
      r_req_valid  = (issued < 8);
      r_req_addr   = AW'(issued);
      #1;
      if (stall) begin
        n_checks++;
        if (r_req_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL stream_stall_ready c=%0d: r_req_ready=%b want 0", c, r_req_ready);
        end
      end
      if (r_resp_valid && r_resp_ready) begin
        n_checks++;
        if (recv >= 8 || r_resp_data !== pat(recv)) begin
          n_errors++;
          $display("FAIL stream_resp[%0d]: data=%h want %h", recv, r_resp_data, pat(recv));
        end
        recv++;
      end
      if (r_req_valid && r_req_ready) issued++;
      tick();
    end
    r_req_valid = 1'b0;
    n_checks++;
    if (recv !== 8 || r_resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_count: recv=%0d valid=%b want recv=8 valid=0", recv, r_resp_valid);
    end
  endtask

  task automatic test_contention();
    logic wexp;
    r_resp_ready = 1'b1;
    w_valid      = 1'b1;
    w_addr       = 9'd30;
    w_data       = pat(30);
    w_mask       = 4'hf;
    r_req_valid  = 1'b1;
    r_req_addr   = 9'd0;
    for (int k = 0; k < 6; k++) begin
      wexp = (k % 2 == 0);
      #1;
      n_checks++;
      if ({w_ready, r_req_ready, sram_en, sram_wmode} !== {wexp, !wexp, 1'b1, wexp}) begin
        n_errors++;
        $display("FAIL contention[%0d]: got wr,rr,en,wm=%b want %b", k,
                 {w_ready, r_req_ready, sram_en, sram_wmode}, {wexp, !wexp, 1'b1, wexp});
      end
      tick();
    end
    w_valid     = 1'b0;
    r_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_zero_mask();
    do_write(9'd9, pat(9), 4'hf);
    w_valid = 1'b1;
    w_addr  = 9'd9;
    w_data  = '1;
    w_mask  = 4'h0;
    #1;
    n_checks++;
    if ({w_ready, sram_en} !== 2'b10) begin
      n_errors++;
      $display("FAIL zero_mask_write: wr,en=%b want 10", {w_ready, sram_en});
    end
    tick();
    w_valid      = 1'b0;
    r_req_valid  = 1'b1;
    r_req_addr   = 9'd9;
    r_resp_ready = 1'b1;
    tick();
    r_req_valid = 1'b0;
    #1;
    n_checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== pat(9)) begin
      n_errors++;
      $display("FAIL zero_mask_read: valid=%b data=%h want %h", r_resp_valid, r_resp_data, pat(9));
    end
    tick();
  endtask

  task automatic test_reset_held();
    int cycles;
    int stale;
    r_resp_ready = 1'b0;
    r_req_valid  = 1'b1;
    r_req_addr   = 9'd9;
    #1;
    n_checks++;
    if (r_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rh_req: r_req_ready=%b want 1", r_req_ready);
    end
    tick();
    r_req_valid = 1'b0;
    tick();
    n_checks++;
    if ({r_resp_valid, r_req_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL rh_held: valid,rr=%b want 10", {r_resp_valid, r_req_ready});
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({r_resp_valid, init_done, sram_en, w_ready, r_req_ready} !== 5'b0) begin
      n_errors++;
      $display("FAIL rh_reset_now: got %b want 00000",
               {r_resp_valid, init_done, sram_en, w_ready, r_req_ready});
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({sram_en, sram_wmode, sram_addr} !== {2'b11, 9'd0}) begin
      n_errors++;
      $display("FAIL rh_sweep_restart: en,wm,addr=%b want %b",
               {sram_en, sram_wmode, sram_addr}, {2'b11, 9'd0});
    end
    cycles = 1;
    stale  = 0;
    while (!init_done && cycles < 600) begin
      if (r_resp_valid) stale++;
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != 513 || stale != 0) begin
      n_errors++;
      $display("FAIL rh_reinit: cycles=%0d stale=%0d want 513 and 0", cycles, stale);
    end
    tick();
    tick();
    n_checks++;
    if (r_resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rh_no_stale: r_resp_valid=%b want 0", r_resp_valid);
    end
    r_resp_ready = 1'b1;
    r_req_valid  = 1'b1;
    r_req_addr   = 9'd9;
    tick();
    r_req_valid = 1'b0;
    #1;
    n_checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== '0) begin
      n_errors++;
      $display("FAIL rh_cleared: valid=%b data=%h want valid=1 data=0", r_resp_valid, r_resp_data);
    end
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    w_valid      = 1'b0;
    w_addr       = '0;
    w_data       = '0;
    w_mask       = '0;
    r_req_valid  = 1'b0;
    r_req_addr   = '0;
    r_resp_ready = 1'b0;
    test_reset();
    test_masked_write();
    test_stream();
    test_contention();
    test_zero_mask();
    test_reset_held();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
